// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/stall sequencer for the fetch -> decode -> readreg front end.
// Resolves memory wait, taken-branch flush and load-use hazards, driving per-stage update
// enables plus the bubble/flush controls of the readreg/decode pipeline registers.
// Optional feature macro: STALL_PERF_CNT_EN -- when defined, stall_cycles is a saturating
// count of cycles with update_fetch==0; when undefined, stall_cycles is tied to zero.
module pipeline_stall_ctrl #(
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        dec_num_Rm,
    input  logic [2:0]        dec_num_Rn,
    input  logic [2:0]        dec_used_RmRnRd,
    input  logic              rr_loads,
    input  logic [2:0]        rr_num_Rd,
    input  logic              rr_used_Rd,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              update_fetch,
    output logic              update_decode,
    output logic              update_readreg,
    output logic              bubble_readreg,
    output logic              flush_decode,
    output logic [1:0]        ctrl_state,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam bit         HAS_LOAD_STALL = (LOAD_LAT > 1);
    localparam bit         HAS_FLUSH      = (FLUSH_SLOTS > 0);
    localparam logic [3:0] LU_RELOAD      = HAS_LOAD_STALL ? 4'(LOAD_LAT - 2) : 4'd0;
    localparam logic [3:0] FL_RELOAD      = HAS_FLUSH ? 4'(FLUSH_SLOTS - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hazard_lu;
    logic       mem_wait;

    assign hazard_lu = rr_loads & rr_used_Rd &
                       ((dec_used_RmRnRd[2] & (dec_num_Rm == rr_num_Rd)) |
                        (dec_used_RmRnRd[1] & (dec_num_Rn == rr_num_Rd)));
    assign mem_wait  = mem_req & ~mem_ready;

    assign ctrl_state = state_q;

    // State and countdown register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Mealy output decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        update_fetch   = 1'b1;
        update_decode  = 1'b1;
        update_readreg = 1'b1;
        bubble_readreg = 1'b0;
        flush_decode   = 1'b0;

        if (rst) begin
            bubble_readreg = 1'b1;
            flush_decode   = 1'b1;
            state_d        = RUN;
            cnt_d          = '0;
        end else if (mem_wait) begin
            // Freeze everything; a stall/flush in progress keeps its state and count,
            // otherwise park in MEM_WAIT until the access completes.
            update_fetch   = 1'b0;
            update_decode  = 1'b0;
            update_readreg = 1'b0;
            if (state_q == RUN) begin
                state_d = MEM_WAIT;
            end
        end else if (branch_taken) begin
            // Branch wins in every state; any load-use stall in progress is abandoned.
            bubble_readreg = 1'b1;
            flush_decode   = 1'b1;
            if (HAS_FLUSH) begin
                state_d = FLUSH;
                cnt_d   = FL_RELOAD;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    // MEM_WAIT's completion cycle is evaluated exactly like a RUN cycle.
                    state_d = RUN;
                    if (hazard_lu) begin
                        update_fetch   = 1'b0;
                        update_decode  = 1'b0;
                        bubble_readreg = 1'b1;
                        if (HAS_LOAD_STALL) begin
                            state_d = LOAD_STALL;
                            cnt_d   = LU_RELOAD;
                        end
                    end
                end
                LOAD_STALL: begin
                    update_fetch   = 1'b0;
                    update_decode  = 1'b0;
                    bubble_readreg = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                FLUSH: begin
                    bubble_readreg = 1'b1;
                    flush_decode   = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [PERF_W-1:0] stall_q;

    // Saturating count of cycles in which fetch is held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!update_fetch && (stall_q != '1)) begin
            stall_q <= stall_q + PERF_W'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: directed vector table, hand sequences for multi-cycle
// corners, and randomized stimulus against a countdown-based reference model. Two instances
// with different parameters share the same stimulus.
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dec_num_Rm, dec_num_Rn, dec_used_RmRnRd, rr_num_Rd;
    logic       rr_loads, rr_used_Rd, branch_taken, mem_req, mem_ready;

    logic       uf[2], ud[2], ur[2], bub[2], fl[2];
    logic [1:0] cs[2];
    logic [15:0] sc_a;
    logic [2:0]  sc_b;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.LOAD_LAT(2), .FLUSH_SLOTS(1), .PERF_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .dec_num_Rm(dec_num_Rm), .dec_num_Rn(dec_num_Rn), .dec_used_RmRnRd(dec_used_RmRnRd),
        .rr_loads(rr_loads), .rr_num_Rd(rr_num_Rd), .rr_used_Rd(rr_used_Rd),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .update_fetch(uf[0]), .update_decode(ud[0]), .update_readreg(ur[0]),
        .bubble_readreg(bub[0]), .flush_decode(fl[0]), .ctrl_state(cs[0]), .stall_cycles(sc_a)
    );

    pipeline_stall_ctrl #(.LOAD_LAT(1), .FLUSH_SLOTS(0), .PERF_W(3)) dut_b (
        .clk(clk), .rst(rst),
        .dec_num_Rm(dec_num_Rm), .dec_num_Rn(dec_num_Rn), .dec_used_RmRnRd(dec_used_RmRnRd),
        .rr_loads(rr_loads), .rr_num_Rd(rr_num_Rd), .rr_used_Rd(rr_used_Rd),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .update_fetch(uf[1]), .update_decode(ud[1]), .update_readreg(ur[1]),
        .bubble_readreg(bub[1]), .flush_decode(fl[1]), .ctrl_state(cs[1]), .stall_cycles(sc_b)
    );

    // Output patterns {update_fetch, update_decode, update_readreg, bubble_readreg, flush_decode}
    localparam logic [4:0] O_RUN = 5'b11100, O_FRZ = 5'b00000, O_FLS = 5'b11111,
                           O_LU  = 5'b00110, O_RST = 5'b11111;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining stall/flush cycles after the current one, per instance.
    int     LL[2]   = '{2, 1};
    int     FS[2]   = '{1, 0};
    longint SMAX[2] = '{65535, 7};
    int     lu_left[2], fl_left[2];
    bit     waiting[2], known[2];
    longint stall[2];

    typedef struct {
        bit       rst, ld;
        bit [2:0] rd, rm, rn, du;
        bit       bt, mq, mr;
        bit [4:0] e;
        bit [1:0] st;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t mk(bit r, bit ld, bit [2:0] rd, bit [2:0] rm, bit [2:0] rn,
                                bit [2:0] du, bit bt, bit mq, bit mr, bit [4:0] e, bit [1:0] st);
        vec_t t;
        t.rst = r; t.ld = ld; t.rd = rd; t.rm = rm; t.rn = rn; t.du = du;
        t.bt = bt; t.mq = mq; t.mr = mr; t.e = e; t.st = st;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; rr_loads = t.ld; rr_used_Rd = t.ld; rr_num_Rd = t.rd;
        dec_num_Rm = t.rm; dec_num_Rn = t.rn; dec_used_RmRnRd = t.du;
        branch_taken = t.bt; mem_req = t.mq; mem_ready = t.mr;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // One clock: compare at negedge against the model (and optionally a fixed expectation
    // for instance A), then advance the model at posedge.
    task automatic step(input bit tbl, input logic [4:0] te, input logic [1:0] tst);
        logic [4:0] e[2];
        int         nlu[2], nfl[2];
        bit         nw[2];
        bit         mw, hz;
        logic [1:0] est;
        longint     es;
        @(negedge clk);
        mw = mem_req & ~mem_ready;
        hz = rr_loads & rr_used_Rd &
             ((dec_used_RmRnRd[2] && dec_num_Rm == rr_num_Rd) ||
              (dec_used_RmRnRd[1] && dec_num_Rn == rr_num_Rd));
        for (int k = 0; k < 2; k++) begin
            nlu[k] = lu_left[k]; nfl[k] = fl_left[k]; nw[k] = 1'b0;
            if (rst) begin
                e[k] = O_RST; nlu[k] = 0; nfl[k] = 0;
            end else if (lu_left[k] > 0) begin
                if (mw) e[k] = O_FRZ;
                else if (branch_taken) begin e[k] = O_FLS; nlu[k] = 0; nfl[k] = FS[k]; end
                else begin e[k] = O_LU; nlu[k] = lu_left[k] - 1; end
            end else if (fl_left[k] > 0) begin
                if (mw) e[k] = O_FRZ;
                else if (branch_taken) begin e[k] = O_FLS; nfl[k] = FS[k]; end
                else begin e[k] = O_FLS; nfl[k] = fl_left[k] - 1; end
            end else begin
                if (mw) begin e[k] = O_FRZ; nw[k] = 1'b1; end
                else if (branch_taken) begin e[k] = O_FLS; nfl[k] = FS[k]; end
                else if (hz) begin e[k] = O_LU; nlu[k] = LL[k] - 1; end
                else e[k] = O_RUN;
            end
            est = (lu_left[k] > 0) ? 2'd1 : (fl_left[k] > 0) ? 2'd3 : waiting[k] ? 2'd2 : 2'd0;
`ifdef STALL_PERF_CNT_EN
            es = stall[k];
`else
            es = 0;
`endif
            chk($sformatf("outs_%0d", k), {uf[k], ud[k], ur[k], bub[k], fl[k]}, e[k]);
            if (known[k]) begin
                chk($sformatf("ctrl_state_%0d", k), cs[k], est);
                chk($sformatf("stall_cycles_%0d", k), (k == 0) ? 64'(sc_a) : 64'(sc_b), es);
            end
        end
        if (tbl) begin
            chk("tbl_outs", {uf[0], ud[0], ur[0], bub[0], fl[0]}, te);
            chk("tbl_state", cs[0], tst);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                stall[k] = 0; known[k] = 1'b1;
            end else if (!e[k][4] && stall[k] < SMAX[k]) begin
                stall[k]++;
            end
            lu_left[k] = nlu[k]; fl_left[k] = nfl[k]; waiting[k] = nw[k];
        end
        #1;
    endtask

    initial begin
        longint exp_a;
        for (int k = 0; k < 2; k++) begin
            lu_left[k] = 0; fl_left[k] = 0; waiting[k] = 1'b0; known[k] = 1'b0; stall[k] = 0;
        end

        //                rst ld rd rm rn du      bt mq mr  outs   state
        tv[0]  = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_RST, 0);
        tv[1]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_RUN, 0);
        tv[2]  = mk(0, 1, 3, 0, 3, 3'b010, 0, 0, 0, O_LU,  0);
        tv[3]  = mk(0, 1, 3, 0, 3, 3'b010, 0, 0, 0, O_LU,  1);
        tv[4]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_RUN, 0);
        tv[5]  = mk(0, 1, 3, 0, 3, 3'b000, 0, 0, 0, O_RUN, 0);
        tv[6]  = mk(0, 1, 5, 5, 1, 3'b100, 0, 0, 0, O_LU,  0);
        tv[7]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_LU,  1);
        tv[8]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_RUN, 0);
        tv[9]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0, O_FRZ, 0);
        tv[10] = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0, O_FRZ, 2);
        tv[11] = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0, O_FRZ, 2);
        tv[12] = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0, O_FRZ, 2);
        tv[13] = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, O_RUN, 2);
        tv[14] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_RUN, 0);
        tv[15] = mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 0, O_FLS, 0);
        tv[16] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_FLS, 3);
        tv[17] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_RUN, 0);
        tv[18] = mk(0, 1, 2, 2, 0, 3'b100, 1, 0, 0, O_FLS, 0);
        tv[19] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_FLS, 3);
        tv[20] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, O_RUN, 0);

        // First reset cycle: state not yet defined, only forced outputs are checked.
        drive(tv[0]);
        #1;
        step(0, '0, '0);
        for (int i = 0; i < 21; i++) begin
            drive(tv[i]);
            step(1, tv[i].e, tv[i].st);
        end
        // Stalled cycles in the table: two load-use pairs plus four memory-wait cycles.
`ifdef STALL_PERF_CNT_EN
        exp_a = 8;
`else
        exp_a = 0;
`endif
        chk("stall_total_a", 64'(sc_a), exp_a);

        // Reset while waiting on memory aborts the wait.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); step(1, O_FRZ, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); step(1, O_FRZ, 2);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); step(1, O_RST, 2);
        idle();                                      step(1, O_RUN, 0);

        // Memory wait inside a load-use stall freezes and holds the stall.
        drive(mk(0, 1, 4, 4, 0, 3'b100, 0, 0, 0, 0, 0)); step(1, O_LU, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));      step(1, O_FRZ, 1);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));      step(1, O_FRZ, 1);
        idle();                                          step(1, O_LU, 1);
        idle();                                          step(1, O_RUN, 0);

        // Branch during a flush reloads the flush count.
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); step(1, O_FLS, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); step(1, O_FLS, 3);
        idle();                                      step(1, O_FLS, 3);
        idle();                                      step(1, O_RUN, 0);

        // Branch during a load-use stall abandons the stall.
        drive(mk(0, 1, 6, 0, 6, 3'b010, 0, 0, 0, 0, 0)); step(1, O_LU, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));      step(1, O_FLS, 1);
        idle();                                          step(1, O_FLS, 3);
        idle();                                          step(1, O_RUN, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 63) == 0);
            rr_loads        = ($urandom_range(0, 2) != 0);
            rr_used_Rd      = ($urandom_range(0, 3) != 0);
            rr_num_Rd       = 3'($urandom_range(0, 3));
            dec_num_Rm      = 3'($urandom_range(0, 3));
            dec_num_Rn      = 3'($urandom_range(0, 3));
            dec_used_RmRnRd = 3'($urandom_range(0, 7));
            branch_taken    = ($urandom_range(0, 7) == 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = ($urandom_range(0, 1) == 0);
            step(0, '0, '0);
        end

        // Saturation of the narrow counter in instance B.
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); step(0, '0, '0);
        for (int n = 0; n < 10; n++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            step(0, '0, '0);
        end
`ifdef STALL_PERF_CNT_EN
        chk("stall_sat_b", 64'(sc_b), 64'd7);
`else
        chk("stall_sat_b", 64'(sc_b), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
